// File: rtl/lod_norm_pipe_pkg.sv
// Shared constants, width helper and default result layout for the leading-one normaliser.
package lod_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int LOD_DATA_W = 8;
  localparam int LOD_MANT_W = 4;
  localparam int LOD_POS_W  = clog2(LOD_DATA_W);

  typedef struct packed {
    logic [LOD_MANT_W-1:0] mant;
    logic [LOD_POS_W-1:0]  pos;
    logic                  zero;
    logic                  sticky;
  } lod_res_t;

endpackage

// File: rtl/lod_norm_pipe_if.sv
// Operand-in / result-out handshake bundle; master is the producer/consumer side, slave the pipe.
interface lod_norm_pipe_if import lod_pkg::*; #(
  parameter int DATA_W = LOD_DATA_W,
  parameter int MANT_W = LOD_MANT_W,
  parameter int POS_W  = clog2(DATA_W)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_left;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [POS_W-1:0]  out_pos;
  logic              out_zero;
  logic              out_sticky;

  modport master (
    output in_valid, in_data, in_left, out_ready,
    input  in_ready, out_valid, out_mant, out_pos, out_zero, out_sticky
  );

  modport slave (
    input  in_valid, in_data, in_left, out_ready,
    output in_ready, out_valid, out_mant, out_pos, out_zero, out_sticky
  );
endinterface

// File: rtl/lod_norm_pipe_prio_enc.sv
// Combinational priority encoder: index of the highest set bit, found=0 when input is all zeros.
module lod_prio_enc import lod_pkg::*; #(
  parameter int DATA_W = LOD_DATA_W,
  parameter int POS_W  = clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [POS_W-1:0]  pos,
  output logic              found
);
  always_comb begin
    pos = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) pos = POS_W'(i);
    end
  end

  assign found = |data;
endmodule

// File: rtl/lod_norm_pipe.sv
// Leading-one detect + normalise: position, truncated mantissa, zero and sticky; 2-cycle latency.
// Valid/ready on both sides; in_ready drops only when both stages are full and out_ready is low.
module lod_norm_pipe import lod_pkg::*; #(
  parameter int DATA_W = LOD_DATA_W,
  parameter int MANT_W = LOD_MANT_W,
  parameter int POS_W  = clog2(DATA_W)
) (
  input  logic           clk,
  input  logic           rst,
  lod_norm_pipe_if.slave bus
);
  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [POS_W-1:0]  pos;
    logic              zero;
    logic              sticky;
  } res_t;

  logic              v1;
  logic              v2;
  logic              rdy1;
  logic              rdy2;
  logic [DATA_W-1:0] d1;
  logic              left1;
  res_t              res_q;
  res_t              res_d;
  logic [POS_W-1:0]  p;
  logic              found;
  logic [POS_W-1:0]  sh;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] low_mask;

  assign rdy2 = !v2 || bus.out_ready;
  assign rdy1 = !v1 || rdy2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      d1    <= '0;
      left1 <= 1'b0;
    end else if (rdy1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        d1    <= bus.in_data;
        left1 <= bus.in_left;
      end
    end
  end

  lod_prio_enc #(.DATA_W(DATA_W), .POS_W(POS_W)) u_enc (
    .data  (d1),
    .pos   (p),
    .found (found)
  );

  // Window [p : p-MANT_W+1] when the leading one is high enough, else keep the low MANT_W bits.
  always_comb begin
    res_d    = '0;
    sh       = '0;
    shifted  = '0;
    low_mask = '0;
    if (!found) begin
      res_d.zero = 1'b1;
    end else begin
      res_d.pos = p;
      if (p >= POS_W'(MANT_W - 1)) begin
        sh           = p - POS_W'(MANT_W - 1);
        shifted      = d1 >> sh;
        low_mask     = ~({DATA_W{1'b1}} << sh);
        res_d.mant   = shifted[MANT_W-1:0];
        res_d.sticky = |(d1 & low_mask);
      end else if (left1) begin
        res_d.mant = d1[MANT_W-1:0] << (POS_W'(MANT_W - 1) - p);
      end else begin
        res_d.mant = d1[MANT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      res_q <= '0;
    end else if (rdy2) begin
      v2 <= v1;
      if (v1) res_q <= res_d;
    end
  end

  assign bus.in_ready   = rdy1;
  assign bus.out_valid  = v2;
  assign bus.out_mant   = res_q.mant;
  assign bus.out_pos    = res_q.pos;
  assign bus.out_zero   = res_q.zero;
  assign bus.out_sticky = res_q.sticky;
endmodule
